// File: rtl/aes_stream_arbiter.sv
// aes_stream_arbiter: round-robin lock of one AES-256-CBC core to N AXI-Stream
// requesters for a whole message (key, IV, text). Result blocks are routed back
// to the owner. Forwarding is purely combinational behind a registered grant.
module aes_stream_arbiter #(
  parameter int N          = 2,
  parameter int BLOCK_SIZE = 128
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  // requester input streams
  input  logic [N-1:0]              S_axis_tvalid,
  output logic [N-1:0]              S_axis_tready,
  input  logic [N-1:0]              S_axis_tlast,
  input  logic [N-1:0]              S_axis_tuser,
  input  logic [N*BLOCK_SIZE-1:0]   S_axis_tdata,
  input  logic [N*BLOCK_SIZE/8-1:0] S_axis_tkeep,
  // result streams back to the requesters
  output logic [N-1:0]              M_axis_tvalid,
  input  logic [N-1:0]              M_axis_tready,
  output logic [N-1:0]              M_axis_tlast,
  output logic [N*BLOCK_SIZE-1:0]   M_axis_tdata,
  output logic [N*BLOCK_SIZE/8-1:0] M_axis_tkeep,
  // stream into the core
  output logic                      Core_s_tvalid,
  input  logic                      Core_s_tready,
  output logic [BLOCK_SIZE-1:0]     Core_s_tdata,
  output logic [BLOCK_SIZE/8-1:0]   Core_s_tkeep,
  output logic                      Core_s_tlast,
  output logic                      Core_s_tuser,
  // stream out of the core
  input  logic                      Core_m_tvalid,
  output logic                      Core_m_tready,
  input  logic [BLOCK_SIZE-1:0]     Core_m_tdata,
  input  logic [BLOCK_SIZE/8-1:0]   Core_m_tkeep,
  input  logic                      Core_m_tlast,
  // ownership status
  output logic [N-1:0]              Grant,
  output logic                      Busy
);

  localparam int KEEP_W = BLOCK_SIZE / 8;
  localparam int PTR_W  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_FORWARD = 3'b010,
    ST_DRAIN   = 3'b100
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               busy_q, busy_d;

  logic [PTR_W-1:0]   gnt_idx;
  logic               in_fwd;
  logic               in_ret;
  logic               in_last_hs;
  logic               out_last_hs;
  logic               found;
  logic [PTR_W:0]     scan_sum;
  logic [PTR_W-1:0]   scan_idx;

  assign in_fwd = (state_q == ST_FORWARD);
  assign in_ret = (state_q == ST_FORWARD) || (state_q == ST_DRAIN);

  // Binary index of the current owner, decoded from the one-hot grant register
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) gnt_idx = PTR_W'(i);
    end
  end

  // Zero-latency routing of both stream directions for the owner only
  always_comb begin
    S_axis_tready = '0;
    Core_s_tvalid = 1'b0;
    Core_s_tdata  = '0;
    Core_s_tkeep  = '0;
    Core_s_tlast  = 1'b0;
    Core_s_tuser  = 1'b0;
    M_axis_tvalid = '0;
    M_axis_tlast  = '0;
    M_axis_tdata  = '0;
    M_axis_tkeep  = '0;
    Core_m_tready = 1'b0;
    if (in_fwd) begin
      Core_s_tvalid          = S_axis_tvalid[gnt_idx];
      Core_s_tdata           = S_axis_tdata[int'(gnt_idx)*BLOCK_SIZE +: BLOCK_SIZE];
      Core_s_tkeep           = S_axis_tkeep[int'(gnt_idx)*KEEP_W +: KEEP_W];
      Core_s_tlast           = S_axis_tlast[gnt_idx];
      Core_s_tuser           = S_axis_tuser[gnt_idx];
      S_axis_tready[gnt_idx] = Core_s_tready;
    end
    if (in_ret) begin
      M_axis_tvalid[gnt_idx]                               = Core_m_tvalid;
      M_axis_tlast[gnt_idx]                                = Core_m_tlast;
      M_axis_tdata[int'(gnt_idx)*BLOCK_SIZE +: BLOCK_SIZE] = Core_m_tdata;
      M_axis_tkeep[int'(gnt_idx)*KEEP_W +: KEEP_W]         = Core_m_tkeep;
      Core_m_tready                                        = M_axis_tready[gnt_idx];
    end
  end

  assign in_last_hs  = in_fwd && Core_s_tvalid && Core_s_tready && Core_s_tlast;
  assign out_last_hs = in_ret && Core_m_tvalid && Core_m_tready && Core_m_tlast;

  // Next-state: round-robin pick in idle, drain after input tlast, release on output tlast
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    case (state_q)
      ST_IDLE: begin
        for (int k = 0; k < N; k++) begin
          scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
          if (scan_sum >= (PTR_W+1)'(N)) scan_sum = scan_sum - (PTR_W+1)'(N);
          scan_idx = scan_sum[PTR_W-1:0];
          if (!found && S_axis_tvalid[scan_idx]) begin
            found             = 1'b1;
            grant_d           = '0;
            grant_d[scan_idx] = 1'b1;
            state_d           = ST_FORWARD;
          end
        end
      end
      ST_FORWARD: begin
        if (in_last_hs) state_d = ST_DRAIN;
      end
      default: begin
        state_d = state_q;
      end
    endcase
    // An early output tlast while still forwarding is a core fault; release anyway
    if (out_last_hs) begin
      state_d  = ST_IDLE;
      grant_d  = '0;
      rr_ptr_d = (gnt_idx == PTR_W'(N-1)) ? '0 : gnt_idx + 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State, grant, pointer and busy registers with asynchronous active-low reset
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
    end
  end

  assign Grant = grant_q;
  assign Busy  = busy_q;

endmodule
